// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 8-point FFT pipeline.
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_DATA_W = 12;
  localparam int FFT_IDX_W  = 3;

  // Stage-2 words are Q7.5; the final halving makes the output Q8.4.
  localparam int STAGE2_INT_W  = 7;
  localparam int STAGE2_FRAC_W = 5;
  localparam int STAGE3_INT_W  = 8;
  localparam int STAGE3_FRAC_W = 4;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } s3_state_t;

  function automatic logic [FFT_IDX_W-1:0] bitrev3(input logic [FFT_IDX_W-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Radix-2 butterfly with W^0 twiddle and 1/2 scaling on a complex pair.
// Define FFT_STAGE3_ROUND_EN for round-half-up instead of truncation.
module fft_bfly2 #(
  parameter int DATA_W = 12
) (
  input  logic signed [DATA_W-1:0] a_re_i,
  input  logic signed [DATA_W-1:0] a_im_i,
  input  logic signed [DATA_W-1:0] b_re_i,
  input  logic signed [DATA_W-1:0] b_im_i,
  output logic signed [DATA_W-1:0] sum_re_o,
  output logic signed [DATA_W-1:0] sum_im_o,
  output logic signed [DATA_W-1:0] diff_re_o,
  output logic signed [DATA_W-1:0] diff_im_o
);

  logic signed [DATA_W:0] aReExt, aImExt, bReExt, bImExt;
  logic signed [DATA_W:0] sumRe, sumIm, diffRe, diffIm;

  assign aReExt = {a_re_i[DATA_W-1], a_re_i};
  assign aImExt = {a_im_i[DATA_W-1], a_im_i};
  assign bReExt = {b_re_i[DATA_W-1], b_re_i};
  assign bImExt = {b_im_i[DATA_W-1], b_im_i};

`ifdef FFT_STAGE3_ROUND_EN
  localparam logic signed [DATA_W:0] RND_ONE = 1;
  assign sumRe  = aReExt + bReExt + RND_ONE;
  assign sumIm  = aImExt + bImExt + RND_ONE;
  assign diffRe = aReExt - bReExt + RND_ONE;
  assign diffIm = aImExt - bImExt + RND_ONE;
`else
  assign sumRe  = aReExt + bReExt;
  assign sumIm  = aImExt + bImExt;
  assign diffRe = aReExt - bReExt;
  assign diffIm = aImExt - bImExt;
`endif

  // Dropping the LSB of the widened result is the arithmetic shift by one.
  assign sum_re_o  = sumRe[DATA_W:1];
  assign sum_im_o  = sumIm[DATA_W:1];
  assign diff_re_o = diffRe[DATA_W:1];
  assign diff_im_o = diffIm[DATA_W:1];

endmodule

// File: rtl/fft_stage3_out.sv
// Final DIF butterfly stage of the 8-point FFT; buffers the frame and streams
// bins in natural order over valid/ready. Rounding mode: FFT_STAGE3_ROUND_EN.
module fft_stage3_out
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int NPTS   = FFT_N
) (
  input  logic                     CLK,
  input  logic                     nRESET,
  input  logic                     stage2_done,
  input  logic signed [DATA_W-1:0] x_stage2_real  [0:NPTS-1],
  input  logic signed [DATA_W-1:0] x_stage2_image [0:NPTS-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_image,
  output logic [2:0]               out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun,
  output logic                     stage3_done
);

  logic signed [DATA_W-1:0] yRe [0:NPTS-1];
  logic signed [DATA_W-1:0] yIm [0:NPTS-1];

  for (genvar m = 0; m < NPTS / 2; m++) begin : g_bfly
    fft_bfly2 #(.DATA_W(DATA_W)) u_bfly (
      .a_re_i    (x_stage2_real[2*m]),
      .a_im_i    (x_stage2_image[2*m]),
      .b_re_i    (x_stage2_real[2*m+1]),
      .b_im_i    (x_stage2_image[2*m+1]),
      .sum_re_o  (yRe[2*m]),
      .sum_im_o  (yIm[2*m]),
      .diff_re_o (yRe[2*m+1]),
      .diff_im_o (yIm[2*m+1])
    );
  end

  s3_state_t                state_q;
  logic signed [DATA_W-1:0] bufRe_q [0:NPTS-1];
  logic signed [DATA_W-1:0] bufIm_q [0:NPTS-1];
  logic signed [DATA_W-1:0] outRe_q, outIm_q;
  logic [2:0]               outIndex_q;
  logic [2:0]               nextIndex_d;
  logic                     outValid_q, outLast_q, overrun_q, done_q;

  assign nextIndex_d = outIndex_q + 3'd1;

  // Outputs are registered and preloaded with the next bin on each handshake,
  // so they stay stable while the consumer stalls.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      outRe_q    <= '0;
      outIm_q    <= '0;
      outIndex_q <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NPTS; i++) begin
        bufRe_q[i] <= '0;
        bufIm_q[i] <= '0;
      end
    end else begin
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (stage2_done) begin
            for (int i = 0; i < NPTS; i++) begin
              bufRe_q[i] <= yRe[i];
              bufIm_q[i] <= yIm[i];
            end
            outRe_q    <= yRe[0];
            outIm_q    <= yIm[0];
            outIndex_q <= '0;
            outValid_q <= 1'b1;
            outLast_q  <= 1'b0;
            state_q    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (stage2_done) begin
            overrun_q <= 1'b1;
          end
          if (out_ready) begin
            if (outIndex_q == 3'd7) begin
              outValid_q <= 1'b0;
              outLast_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              outIndex_q <= nextIndex_d;
              outRe_q    <= bufRe_q[bitrev3(nextIndex_d)];
              outIm_q    <= bufIm_q[bitrev3(nextIndex_d)];
              outLast_q  <= (nextIndex_d == 3'd7);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = outValid_q;
  assign out_real    = outRe_q;
  assign out_image   = outIm_q;
  assign out_index   = outIndex_q;
  assign out_last    = outLast_q;
  assign busy        = (state_q == ST_STREAM);
  assign overrun     = overrun_q;
  assign stage3_done = done_q;

endmodule

// File: tb/tb_fft_stage3_out.sv
// Directed and random bench for fft_stage3_out; expected bins come from a
// behavioural last-stage model and hand-computed vectors.
module tb_fft_stage3_out;

  logic              CLK = 1'b0;
  logic              nRESET = 1'b0;
  logic              stage2_done = 1'b0;
  logic signed [11:0] x_stage2_real  [0:7];
  logic signed [11:0] x_stage2_image [0:7];
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [11:0] out_real;
  logic signed [11:0] out_image;
  logic [2:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic              stage3_done;

  int checks = 0;
  int failures = 0;
  int fRe[8];
  int fIm[8];

  fft_stage3_out dut (
    .CLK            (CLK),
    .nRESET         (nRESET),
    .stage2_done    (stage2_done),
    .x_stage2_real  (x_stage2_real),
    .x_stage2_image (x_stage2_image),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_real       (out_real),
    .out_image      (out_image),
    .out_index      (out_index),
    .out_last       (out_last),
    .busy           (busy),
    .overrun        (overrun),
    .stage3_done    (stage3_done)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap12(input int v);
    logic [31:0] t;
    t = v;
    return int'({{20{t[11]}}, t[11:0]});
  endfunction

  function automatic int bflyModel(input int a, input int b, input bit isDiff);
    int s;
    s = isDiff ? a - b : a + b;
`ifdef FFT_STAGE3_ROUND_EN
    s = s + 1;
`endif
    return wrap12(s >>> 1);
  endfunction

  function automatic int revIdx(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic buildExpected(output int eRe[8], output int eIm[8]);
    for (int k = 0; k < 8; k++) begin
      int j, m;
      j = revIdx(k);
      m = j / 2;
      eRe[k] = bflyModel(fRe[2*m], fRe[2*m+1], j[0]);
      eIm[k] = bflyModel(fIm[2*m], fIm[2*m+1], j[0]);
    end
  endtask

  // Drives the frame in fRe/fIm with a one-cycle stage2_done; returns #1 after the capture edge.
  task automatic applyStimulus();
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      x_stage2_real[i]  = 12'(fRe[i]);
      x_stage2_image[i] = 12'(fIm[i]);
    end
    stage2_done = 1'b1;
    @(posedge CLK);
    #1;
    stage2_done = 1'b0;
  endtask

  task automatic collectFrame(input string tag, input int eRe[8], input int eIm[8],
                              input int stallAt, input int overrunAt, input bit randReady);
    int k = 0;
    int cyc = 0;
    int stallLeft = 3;
    int ovrPhase = 0;
    while (k < 8 && cyc < 200) begin
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == stallAt && stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end
      checkOutput({tag, " valid"}, out_valid, 1);
      checkOutput({tag, " index"}, out_index, k);
      checkOutput({tag, " last"}, out_last, (k == 7) ? 1 : 0);
      checkOutput({tag, " real"}, out_real, eRe[k]);
      checkOutput({tag, " imag"}, out_image, eIm[k]);
      if (ovrPhase == 1) begin
        checkOutput({tag, " overrun pulse"}, overrun, 1);
        ovrPhase = 2;
      end else if (ovrPhase == 2) begin
        checkOutput({tag, " overrun cleared"}, overrun, 0);
        ovrPhase = 3;
      end
      if (k == overrunAt && ovrPhase == 0) begin
        for (int i = 0; i < 8; i++) begin
          x_stage2_real[i]  = 12'sd100;
          x_stage2_image[i] = -12'sd100;
        end
        stage2_done = 1'b1;
        ovrPhase = 1;
      end
      @(posedge CLK);
      #1;
      stage2_done = 1'b0;
      if (out_ready) begin
        if (k == 7) begin
          checkOutput({tag, " done pulse"}, stage3_done, 1);
          checkOutput({tag, " busy after"}, busy, 0);
          checkOutput({tag, " valid after"}, out_valid, 0);
          checkOutput({tag, " last after"}, out_last, 0);
        end else begin
          checkOutput({tag, " no early done"}, stage3_done, 0);
        end
        k++;
      end
      cyc++;
    end
    if (k < 8) checkOutput({tag, " timeout bins"}, k, 8);
    if (ovrPhase == 1) checkOutput({tag, " overrun at end"}, overrun, 1);
    out_ready = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      checkOutput({tag, " idle valid"}, out_valid, 0);
      checkOutput({tag, " idle busy"}, busy, 0);
      checkOutput({tag, " idle done"}, stage3_done, 0);
    end
  endtask

  initial begin
    int eRe[8];
    int eIm[8];
    for (int i = 0; i < 8; i++) begin
      x_stage2_real[i]  = '0;
      x_stage2_image[i] = '0;
    end

    #3;
    checkOutput("reset valid", out_valid, 0);
    checkOutput("reset real", out_real, 0);
    checkOutput("reset imag", out_image, 0);
    checkOutput("reset index", out_index, 0);
    checkOutput("reset last", out_last, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset done", stage3_done, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    checkIdle("post reset");

    // Impulse pair: only bin 4 carries energy.
    fRe = '{32, -32, 0, 0, 0, 0, 0, 0};
    fIm = '{0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus();
    checkOutput("impulse busy", busy, 1);
    collectFrame("impulse", '{0, 0, 0, 0, 32, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 1'b0);
    checkIdle("impulse");

    // Odd sums expose the rounding mode; a frame arrives with the final handshake.
    fRe = '{3, 0, 0, 0, 0, 0, 0, 0};
    fIm = '{-3, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus();
`ifdef FFT_STAGE3_ROUND_EN
    collectFrame("rounding", '{2, 0, 0, 0, 2, 0, 0, 0}, '{-1, 0, 0, 0, -1, 0, 0, 0}, -1, 7, 1'b0);
`else
    collectFrame("rounding", '{1, 0, 0, 0, 1, 0, 0, 0}, '{-2, 0, 0, 0, -2, 0, 0, 0}, -1, 7, 1'b0);
`endif
    checkIdle("rounding");

    // Exactly divisible frame shared by the stall, overrun and reset tests.
    fRe = '{10, 6, 0, 0, 20, -4, 0, 0};
    fIm = '{0, 0, 8, 2, 0, 0, -6, -10};
    applyStimulus();
    collectFrame("stall", '{8, 8, 0, 0, 2, 12, 0, 0}, '{0, 0, 5, -8, 0, 0, 3, 2}, 2, -1, 1'b0);
    checkIdle("stall");

    applyStimulus();
    collectFrame("overrun", '{8, 8, 0, 0, 2, 12, 0, 0}, '{0, 0, 5, -8, 0, 0, 3, 2}, -1, 5, 1'b0);
    checkIdle("overrun");

    applyStimulus();
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("pre-reset index", out_index, 3);
    checkOutput("pre-reset imag", out_image, -8);
    #2;
    nRESET = 1'b0;
    #1;
    checkOutput("async reset valid", out_valid, 0);
    checkOutput("async reset imag", out_image, 0);
    checkOutput("async reset index", out_index, 0);
    checkOutput("async reset busy", busy, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    checkIdle("after reset");
    fRe = '{32, -32, 0, 0, 0, 0, 0, 0};
    fIm = '{0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus();
    collectFrame("post-reset frame", '{0, 0, 0, 0, 32, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 1'b0);

    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 8; i++) begin
        fRe[i] = int'($urandom_range(0, 4095)) - 2048;
        fIm[i] = int'($urandom_range(0, 4095)) - 2048;
      end
      buildExpected(eRe, eIm);
      applyStimulus();
      collectFrame("random", eRe, eIm, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage3_out.md
Name: fft_stage3_out

Overview:
- Final radix-2 DIF stage of the 8-point FFT. Consumes the stage-2 frame: 8 complex words, 12-bit, 7 integer / 5 fraction bits, qualified by a one-cycle stage2_done pulse.
- Performs the last butterfly layer with a trivial twiddle W^0 and scales by 1/2.
- Stores the frame in a local buffer and streams the 8 bins out one per cycle, in natural order k=0..7 (bit-reversal undone), over a valid/ready handshake to the downstream consumer.

Parameters:
- DATA_W, 12, width of input/output real and imaginary words; output format is 8 integer / 4 fraction bits.
- NPTS, 8, FFT size; fixed at 8, index width is 3.

Ports:
- CLK  in  1  clock, rising edge
- nRESET  in  1  asynchronous reset, active-low
- stage2_done  in  1  one-cycle pulse; x_stage2_* are valid in the same cycle
- x_stage2_real  in  [0:7] x DATA_W signed  stage-2 real outputs
- x_stage2_image  in  [0:7] x DATA_W signed  stage-2 imaginary outputs
- out_valid  out  1  bin presented on out_*
- out_ready  in  1  consumer accepts the bin when out_valid && out_ready
- out_real  out  DATA_W signed  bin real part
- out_image  out  DATA_W signed  bin imaginary part
- out_index  out  3  bin number k
- out_last  out  1  high with k=7
- busy  out  1  state != IDLE
- overrun  out  1  one-cycle pulse: an incoming frame was dropped
- stage3_done  out  1  one-cycle pulse when bin 7 is accepted

Behaviour:
- Reset is asynchronous, active-low, on nRESET; clock is CLK. Reset may arrive mid-stream and aborts the frame with no partial output afterwards.
- Reset values:
  - out_valid=0, out_real=0, out_image=0, out_index=0, out_last=0
  - busy=0, overrun=0, stage3_done=0
  - frame buffer cleared; state=IDLE
- Butterflies: y[2m]=(a+b)>>>1 and y[2m+1]=(a-b)>>>1, where a=x[2m], b=x[2m+1], m=0..3, applied to real and imaginary parts independently.
  - Operands are sign-extended to DATA_W+1 before add/sub, then arithmetic-shifted right by 1.
  - The result always fits in DATA_W; no saturation is needed.
- Output order: bin k is taken from y[bitrev3(k)], so k=1 maps to y[4], k=3 to y[6], k=4 to y[1], etc.
- State machine:
  - IDLE: on stage2_done=1, register all 8 butterfly results into the buffer, set out_index=0, out_valid=1, go to STREAM. Latency: bin 0 is valid on the first edge after the stage2_done cycle.
  - STREAM: out_* are driven from buffer[bitrev(out_index)].
    - On handshake with out_index<7: increment out_index.
    - On handshake with out_index=7: out_valid=0, stage3_done pulse, go to IDLE.
  - With out_ready=0, all out_* hold stable; valid is never withdrawn until the handshake.
- stage2_done while busy (STREAM): the new frame is dropped and overrun pulses for 1 cycle. The current stream is unaffected.
- stage2_done in the same cycle as the final handshake: the frame is dropped with overrun, because the block is still busy in that cycle.
- out_last is asserted exactly when out_valid && out_index==7.

Optional Feature:
- FFT_STAGE3_ROUND_EN defined: round half up, y=(a±b+1)>>>1. The width remains safe (max (2047+2047+1)>>1 = 2047).
- Undefined: truncation toward -inf, y=(a±b)>>>1, matching the earlier stages.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=8 and FFT_DATA_W=12 constants
  - cplx_t typedef (signed real/imag DATA_W)
  - bitrev3 function
  - stage Q-format constants
- One natural sub-module: fft_bfly2 (sign-extend, add/sub, shift, optional rounding), instantiated 4 times.

Test Plan:
- Directed frame, out_ready=1: real[0]=32, real[1]=-32, all else 0, one stage2_done pulse.
  - Expected: bins 0..7 on 8 consecutive cycles starting the cycle after the pulse.
  - Bin 4 real=32; all other bins 0.
  - out_last and stage3_done coincide with bin 7; busy falls after it.
- Rounding: real[0]=3, real[1]=0.
  - Truncate: bin0=1, bin4=1.
  - With FFT_STAGE3_ROUND_EN: bin0=2, bin4=2.
  - real[0]=-3, real[1]=0 gives bin0=-2 truncate and -1 rounded.
- Backpressure: drop out_ready for 3 cycles while bin 2 is presented.
  - out_index=2, data and out_valid stay constant.
  - The full frame is still delivered in order with no duplicates.
- Overrun: second stage2_done while streaming bin 5.
  - overrun pulses for 1 cycle; remaining bins 5..7 come from the first frame.
  - Block returns to IDLE with no second frame.
- Reset mid-stream: assert nRESET=0 asynchronously at bin 3.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release, a new stage2_done frame streams correctly from bin 0.
- Random frames (1000): compare against a golden 8-point DIF model, bit-exact in both rounding modes, with random out_ready.
